// File: rtl/reg_list_encoder.sv
// reg_list_encoder: walks an N-bit register-list mask and emits the index of
// each set bit, lowest first, one index per accepted output handshake.
//
// Output handshake: an index transfers on any rising clk edge where
// out_valid && out_ready. out_valid stays high and out_index/out_last stay
// stable until that transfer happens; out_valid never depends on out_ready.
module reg_list_encoder #(
  parameter int N = 32,
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] mask,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_index,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output logic [W:0]   count
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic         done_q, done_d;
  logic [W:0]   count_q, count_d;

  logic [N-1:0] lowest_onehot;
  logic [W-1:0] lowest_index;
  logic [W:0]   mask_popcount;

  // Lowest pending bit as a one-hot and as a binary index.
  always_comb begin
    lowest_onehot = pending_q & (~pending_q + {{(N-1){1'b0}}, 1'b1});
    lowest_index  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending_q[i]) lowest_index = W'(i);
    end
  end

  // Number of registers in the incoming list.
  always_comb begin
    mask_popcount = '0;
    for (int i = 0; i < N; i++) begin
      mask_popcount = mask_popcount + {{W{1'b0}}, mask[i]};
    end
  end

  // Outputs come only from registered state.
  always_comb begin
    busy      = (state_q == ST_RUN);
    out_valid = (state_q == ST_RUN);
    out_index = lowest_index;
    // Exactly one bit left: clearing the lowest bit leaves nothing.
    out_last  = (state_q == ST_RUN) && ((pending_q & ~lowest_onehot) == '0);
    done      = done_q;
    count     = count_q;
  end

  // Next-state logic: flush wins over start and over a handshake.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    done_d    = 1'b0;
    if (flush) begin
      state_d   = ST_IDLE;
      pending_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            count_d = mask_popcount;
            if (mask != '0) begin
              pending_d = mask;
              state_d   = ST_RUN;
            end else begin
              // Empty list completes immediately without emitting anything.
              done_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (out_ready) begin
            pending_d = pending_q & ~lowest_onehot;
            if (out_last) begin
              pending_d = '0;
              state_d   = ST_IDLE;
              done_d    = 1'b1;
            end
          end
        end
        default: begin
          state_d   = ST_IDLE;
          pending_d = '0;
        end
      endcase
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      done_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      count_q   <= count_d;
    end
  end

endmodule
